trap_ctrl: RTL

- Trap sequencer for the machine-mode CSR file in the RV32IM single-cycle core.
- Samples exception and interrupt sources at instruction retirement and picks one cause by fixed priority.
- Stalls the core, drives the CSR file's trap_enter/trap_exit/current_pc/exception_code inputs, then issues a one-cycle PC redirect to the handler (mtvec) or the return address (mepc).
- Also sequences MRET.

---
 rtl/trap_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Trap sequencer for the machine-mode CSR file: picks one exception/interrupt
// cause at retirement, strobes the CSR file, then redirects the PC.
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b1,
    parameter bit IRQ_EN      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] pc_in,
    input  logic        exc_fetch_misalign,
    input  logic        exc_illegal,
    input  logic        exc_ebreak,
    input  logic        exc_load_misalign,
    input  logic        exc_store_misalign,
    input  logic        exc_ecall,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    output logic        trap_enter,
    output logic        trap_exit,
    output logic [31:0] trap_pc,
    output logic [31:0] exception_code,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Handshake: there is no backpressure. Each strobe (trap_enter,
    // trap_exit, redirect_valid) is a single-cycle valid that the CSR file
    // and PC logic are always ready to accept in the cycle it is high.

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ENTER    = 2'd1,
        EXIT     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] code_q;
    logic [31:0] pc_q;
    logic        irq_q;
    logic        mret_q;

    logic        detect;
    logic        irq_hit;
    logic        exc_hit;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] cause;
    logic [31:0] mtvec_base;

    // The low bits of mepc are forced to zero on return.
    logic [1:0]  unused_mepc_bits;
    assign unused_mepc_bits = mepc_in[1:0];

    always_comb begin
        detect    = (state == RUN) && instr_valid;
        irq_hit   = IRQ_EN && mstatus_mie && (irq_ext || irq_timer);
        exc_hit   = exc_fetch_misalign || exc_illegal || exc_ebreak ||
                    exc_ecall || exc_load_misalign || exc_store_misalign;
        take_trap = detect && (irq_hit || exc_hit);
        take_mret = detect && mret && !(irq_hit || exc_hit);
    end

    // Interrupts first, then synchronous exceptions in architectural order.
    always_comb begin
        cause = 32'd0;
        if (irq_hit) begin
            cause = irq_ext ? 32'h8000_000B : 32'h8000_0007;
        end else if (exc_fetch_misalign) begin
            cause = 32'd0;
        end else if (exc_illegal) begin
            cause = 32'd2;
        end else if (exc_ebreak) begin
            cause = 32'd3;
        end else if (exc_ecall) begin
            cause = 32'd11;
        end else if (exc_load_misalign) begin
            cause = 32'd4;
        end else if (exc_store_misalign) begin
            cause = 32'd6;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (take_trap) begin
                    state_next = ENTER;
                end else if (take_mret) begin
                    state_next = EXIT;
                end
            end
            ENTER:    state_next = REDIRECT;
            EXIT:     state_next = REDIRECT;
            REDIRECT: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q <= 32'd0;
            pc_q   <= 32'd0;
            irq_q  <= 1'b0;
            mret_q <= 1'b0;
        end else if (take_trap) begin
            code_q <= cause;
            pc_q   <= pc_in;
            irq_q  <= irq_hit;
            mret_q <= 1'b0;
        end else if (take_mret) begin
            mret_q <= 1'b1;
        end
    end

    always_comb begin
        mtvec_base     = {mtvec_in[31:2], 2'b00};
        trap_enter     = (state == ENTER);
        trap_exit      = (state == EXIT);
        redirect_valid = (state == REDIRECT);
        stall          = (state != RUN) || take_trap || take_mret;
        exception_code = code_q;
        trap_pc        = pc_q;
        redirect_pc    = 32'd0;
        if (state == REDIRECT) begin
            if (mret_q) begin
                redirect_pc = {mepc_in[31:2], 2'b00};
            end else if (VECTORED_EN && irq_q && (mtvec_in[1:0] == 2'b01)) begin
                redirect_pc = mtvec_base + {25'd0, code_q[4:0], 2'b00};
            end else begin
                redirect_pc = mtvec_base;
            end
        end
    end

endmodule
